// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: freezes the pipe on memory busy, flushes on taken branches,
// inserts one bubble on load-use, and keeps saturating stall/flush performance counters.
module pipeline_hazard_controller #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       idR1Address,
    input  logic [2:0]       idR2Address,
    input  logic             idUseR1,
    input  logic             idUseR2,
    input  logic [2:0]       exDest,
    input  logic             exRegWrite,
    input  logic             exRegWriteDataSel,
    input  logic             exBranchTaken,
    input  logic             memBusy,
    output logic             pcEnb,
    output logic             ifIdEnb,
    output logic             idExEnb,
    output logic             ifIdFlush,
    output logic             idExFlush,
    output logic             hazState,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } haz_state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    haz_state_e       state_q, state_d;
    logic             pend_flush_q, pend_flush_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use_s;
    logic             stall_inc_s;
    logic             flush_inc_s;

    assign load_use_s = exRegWrite & exRegWriteDataSel &
                        ((idUseR1 & (idR1Address == exDest)) |
                         (idUseR2 & (idR2Address == exDest)));

    // Hazard priority decode: memBusy > flush > load-use > normal; outputs forced low in reset
    always_comb begin
        pcEnb        = 1'b0;
        ifIdEnb      = 1'b0;
        idExEnb      = 1'b0;
        ifIdFlush    = 1'b0;
        idExFlush    = 1'b0;
        state_d      = state_q;
        pend_flush_d = pend_flush_q;
        stall_inc_s  = 1'b0;
        flush_inc_s  = 1'b0;
        if (!rst) begin
            state_d      = RUN;
            pend_flush_d = 1'b0;
        end else if (memBusy) begin
            // A branch resolving during a freeze must survive until the pipe moves again
            state_d      = HOLD;
            pend_flush_d = pend_flush_q | exBranchTaken;
            stall_inc_s  = 1'b1;
        end else if (exBranchTaken | pend_flush_q) begin
            pcEnb        = 1'b1;
            ifIdEnb      = 1'b1;
            idExEnb      = 1'b1;
            ifIdFlush    = 1'b1;
            idExFlush    = 1'b1;
            state_d      = RUN;
            pend_flush_d = 1'b0;
            flush_inc_s  = 1'b1;
        end else if (load_use_s) begin
            idExEnb      = 1'b1;
            idExFlush    = 1'b1;
            state_d      = RUN;
            stall_inc_s  = 1'b1;
        end else begin
            pcEnb        = 1'b1;
            ifIdEnb      = 1'b1;
            idExEnb      = 1'b1;
            state_d      = RUN;
        end
    end

    // Saturating next-state for both performance counters
    always_comb begin
        stall_d     = stall_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc_s && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end else begin
            stall_d = stall_q;
        end
        if (flush_inc_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State, pending-flush flag and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            pend_flush_q <= 1'b0;
            stall_q      <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pend_flush_q <= pend_flush_d;
            stall_q      <= stall_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign hazState    = state_q;
    assign stallCycles = stall_q;
    assign flushCount  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: directed vectors push hand-computed expectations; a negedge monitor
// pops and compares against an 8-bit-counter DUT and a 2-bit-counter DUT sharing inputs.
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] idR1Address = 3'd0, idR2Address = 3'd0, exDest = 3'd0;
    logic       idUseR1 = 1'b0, idUseR2 = 1'b0;
    logic       exRegWrite = 1'b0, exRegWriteDataSel = 1'b0;
    logic       exBranchTaken = 1'b0, memBusy = 1'b0;

    logic       pcEnb, ifIdEnb, idExEnb, ifIdFlush, idExFlush, hazState;
    logic [7:0] stallCycles, flushCount;
    logic       pcEnb2, ifIdEnb2, idExEnb2, ifIdFlush2, idExFlush2, hazState2;
    logic [1:0] stallCycles2, flushCount2;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [2:0] en;   // {pcEnb, ifIdEnb, idExEnb}
        logic [1:0] fl;   // {ifIdFlush, idExFlush}
        logic       haz;
        logic [7:0] st;
        logic [7:0] fc;
    } exp_t;

    exp_t exp_q[$];

    pipeline_hazard_controller dut (
        .clk(clk), .rst(rst),
        .idR1Address(idR1Address), .idR2Address(idR2Address),
        .idUseR1(idUseR1), .idUseR2(idUseR2),
        .exDest(exDest), .exRegWrite(exRegWrite), .exRegWriteDataSel(exRegWriteDataSel),
        .exBranchTaken(exBranchTaken), .memBusy(memBusy),
        .pcEnb(pcEnb), .ifIdEnb(ifIdEnb), .idExEnb(idExEnb),
        .ifIdFlush(ifIdFlush), .idExFlush(idExFlush), .hazState(hazState),
        .stallCycles(stallCycles), .flushCount(flushCount)
    );

    pipeline_hazard_controller #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .idR1Address(idR1Address), .idR2Address(idR2Address),
        .idUseR1(idUseR1), .idUseR2(idUseR2),
        .exDest(exDest), .exRegWrite(exRegWrite), .exRegWriteDataSel(exRegWriteDataSel),
        .exBranchTaken(exBranchTaken), .memBusy(memBusy),
        .pcEnb(pcEnb2), .ifIdEnb(ifIdEnb2), .idExEnb(idExEnb2),
        .ifIdFlush(ifIdFlush2), .idExFlush(idExFlush2), .hazState(hazState2),
        .stallCycles(stallCycles2), .flushCount(flushCount2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are settled mid-cycle, so compare on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("enables", int'({pcEnb, ifIdEnb, idExEnb}), int'(e.en));
            check("flushes", int'({ifIdFlush, idExFlush}), int'(e.fl));
            check("hazState", int'(hazState), int'(e.haz));
            check("stallCycles", int'(stallCycles), int'(e.st));
            check("flushCount", int'(flushCount), int'(e.fc));
            check("stallCycles_w2", int'(stallCycles2), (e.st > 8'd3) ? 3 : int'(e.st));
            check("flushCount_w2", int'(flushCount2), (e.fc > 8'd3) ? 3 : int'(e.fc));
            check("controls_w2", int'({pcEnb2, ifIdEnb2, idExEnb2, ifIdFlush2, idExFlush2, hazState2}),
                  int'({e.en, e.fl, e.haz}));
        end
    end

    task automatic vec(input logic r, input logic busy, input logic br,
                       input logic rw, input logic sel, input logic [2:0] dst,
                       input logic u1, input logic [2:0] a1,
                       input logic u2, input logic [2:0] a2,
                       input logic [2:0] en, input logic [1:0] fl, input logic haz,
                       input int st, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; memBusy = busy; exBranchTaken = br;
        exRegWrite = rw; exRegWriteDataSel = sel; exDest = dst;
        idUseR1 = u1; idR1Address = a1; idUseR2 = u2; idR2Address = a2;
        e.en  = en;
        e.fl  = fl;
        e.haz = haz;
        e.st  = (st > 255) ? 8'd255 : 8'(st);
        e.fc  = (fc > 255) ? 8'd255 : 8'(fc);
        exp_q.push_back(e);
    endtask

    initial begin
        //   rst busy br rw sel dst  u1 a1   u2 a2     en     fl   haz st fc
        vec(1'b0,1'b0,1'b0,1'b1,1'b1,3'd3,1'b1,3'd3,1'b0,3'd0, 3'b000,2'b00,1'b0,0,0);
        vec(1'b0,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b000,2'b00,1'b0,0,0);
        vec(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b111,2'b00,1'b0,0,0);
        // load-use on R1, then bubble in EX
        vec(1'b1,1'b0,1'b0,1'b1,1'b1,3'd3,1'b1,3'd3,1'b0,3'd0, 3'b001,2'b01,1'b0,0,0);
        vec(1'b1,1'b0,1'b0,1'b0,1'b1,3'd3,1'b1,3'd3,1'b0,3'd0, 3'b111,2'b00,1'b0,1,0);
        // no false hazard: source unused, then not a load
        vec(1'b1,1'b0,1'b0,1'b1,1'b1,3'd3,1'b0,3'd3,1'b0,3'd0, 3'b111,2'b00,1'b0,1,0);
        vec(1'b1,1'b0,1'b0,1'b1,1'b0,3'd3,1'b1,3'd3,1'b0,3'd0, 3'b111,2'b00,1'b0,1,0);
        // load-use via R2, and register 0 is not special
        vec(1'b1,1'b0,1'b0,1'b1,1'b1,3'd3,1'b0,3'd0,1'b1,3'd3, 3'b001,2'b01,1'b0,1,0);
        vec(1'b1,1'b0,1'b0,1'b1,1'b1,3'd0,1'b1,3'd0,1'b0,3'd5, 3'b001,2'b01,1'b0,2,0);
        // branch overrides load-use
        vec(1'b1,1'b0,1'b1,1'b1,1'b1,3'd3,1'b1,3'd3,1'b0,3'd0, 3'b111,2'b11,1'b0,3,0);
        vec(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b111,2'b00,1'b0,3,1);
        // 4-cycle freeze with branch in the first cycle, flush when released
        vec(1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b000,2'b00,1'b0,3,1);
        vec(1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b000,2'b00,1'b1,4,1);
        vec(1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b000,2'b00,1'b1,5,1);
        vec(1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b000,2'b00,1'b1,6,1);
        vec(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b111,2'b11,1'b1,7,1);
        vec(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b111,2'b00,1'b0,7,2);
        // plain branch pulse
        vec(1'b1,1'b0,1'b1,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b111,2'b11,1'b0,7,2);
        vec(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b111,2'b00,1'b0,7,3);
        // asynchronous reset mid-HOLD with a pending flush
        vec(1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b000,2'b00,1'b0,7,3);
        vec(1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b000,2'b00,1'b1,8,3);
        vec(1'b0,1'b1,1'b0,1'b1,1'b1,3'd3,1'b1,3'd3,1'b0,3'd0, 3'b000,2'b00,1'b0,0,0);
        vec(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b111,2'b00,1'b0,0,0);
        vec(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b111,2'b00,1'b0,0,0);
        // pending flush plus a fresh branch on release counts once
        vec(1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b000,2'b00,1'b0,0,0);
        vec(1'b1,1'b0,1'b1,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b111,2'b11,1'b1,1,0);
        vec(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b111,2'b00,1'b0,1,1);
        // drive both 8-bit counters into saturation
        for (int i = 0; i < 260; i++) begin
            vec(1'b1,1'b0,1'b1,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b111,2'b11,1'b0,1,1 + i);
        end
        for (int i = 0; i < 260; i++) begin
            vec(1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b000,2'b00,(i > 0) ? 1'b1 : 1'b0,1 + i,261);
        end
        vec(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b111,2'b00,1'b1,261,261);
        vec(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, 3'b111,2'b00,1'b0,261,261);
        @(posedge clk);
        @(posedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d queued expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
